// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Big-endian lane select, sign/zero extension, sub-word RMW, misalign detect.
module load_store_unit #(
    parameter int BADDR_W = 10,
    parameter int WADDR_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [BADDR_W-1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [WADDR_W-1:0] mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic [BADDR_W-1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_word;
    logic                 r_err;
    logic [WADDR_W-1:0]   r_maddr;

    logic                 w_accept;
    logic                 w_misal;
    logic [WADDR_W-1:0]   w_waddr;
    logic [4:0]           w_bsh;
    logic [4:0]           w_hsh;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_bmask;
    logic [31:0]          w_hmask;
    logic [31:0]          w_load;
    logic [31:0]          w_merge;

    assign w_accept = req_valid & req_ready;
    assign w_misal  = ((req_size == 2'b01) & req_addr[0]) |
                      (req_size[1] & (req_addr[1:0] != 2'b00));
    assign w_waddr  = r_addr[2 +: WADDR_W];

    // Big-endian lanes: byte offset 0 and half offset 0 sit in the MSBs,
    // so the right-shift amount is the inverted offset.
    assign w_bsh   = {~r_addr[1:0], 3'b000};
    assign w_hsh   = {~r_addr[1], 4'b0000};
    assign w_byte  = 8'(r_word >> w_bsh);
    assign w_half  = 16'(r_word >> w_hsh);
    assign w_bmask = 32'h0000_00FF << w_bsh;
    assign w_hmask = 32'h0000_FFFF << w_hsh;

    // Right-justify the addressed lane and extend it
    always_comb begin
        w_load = r_word;
        unique case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = r_word;
        endcase
    end

    // Replace only the addressed lane of the captured word
    always_comb begin
        w_merge = r_wdata;
        unique case (r_size)
            2'b00:   w_merge = (r_word & ~w_bmask) |
                               (({24'h0, r_wdata[7:0]} << w_bsh) & w_bmask);
            2'b01:   w_merge = (r_word & ~w_hmask) |
                               (({16'h0, r_wdata[15:0]} << w_hsh) & w_hmask);
            default: w_merge = r_wdata;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the request on accept
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_misal;
        end
    end

    // Capture read data and remember the last word address driven
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_word  <= 32'h0;
            r_maddr <= '0;
        end else begin
            if (r_state == S_RD) begin
                r_word <= mem_rdata;
            end
            if ((r_state == S_RD) || (r_state == S_WR)) begin
                r_maddr <= w_waddr;
            end
        end
    end

    // Next state and all outputs decoded from state
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = r_maddr;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = RST_N;
                if (req_valid & RST_N) begin
                    if (w_misal) begin
                        w_next = S_DONE;
                    end else if (req_we & req_size[1]) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_rd   = 1'b1;
                mem_addr = w_waddr;
                w_next   = r_we ? S_WR : S_DONE;
            end
            S_WR: begin
                mem_wr    = RST_N;
                mem_addr  = w_waddr;
                mem_wdata = w_merge;
                w_next    = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_err | r_we) ? 32'h0 : w_load;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-array reference model,
// directed test-plan cases plus randomized loads and stores.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    logic [7:0]  rm [1024];
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
        logic [7:0]  waddr;
        logic        rdy;
    } obs_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [31:0] wword;
    } exp_t;

    load_store_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_a] <= pl_d;
    end

    function automatic logic [31:0] ref_word(input int w);
        return {rm[4*w], rm[4*w+1], rm[4*w+2], rm[4*w+3]};
    endfunction

    // Expected outcome straight from the access rules, on a byte array
    function automatic exp_t model(input logic we, input logic [1:0] sz,
                                   input logic sg, input logic [9:0] a,
                                   input logic [31:0] wd);
        exp_t e;
        int ia;
        int base;
        int off;
        logic [7:0] bb [4];
        logic [7:0] b;
        logic [15:0] h;
        ia = int'(a);
        base = ia & ~3;
        off = ia & 3;
        e.err = ((sz == 2'd1) && (off % 2 == 1)) || (sz[1] && off != 0);
        e.rdata = 32'h0;
        e.wword = 32'h0;
        e.nrd = 0;
        e.nwr = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            e.nrd = 1;
            if (sz == 2'd0) begin
                b = rm[ia];
                e.rdata = sg ? {{24{b[7]}}, b} : {24'h0, b};
            end else if (sz == 2'd1) begin
                h = {rm[ia], rm[ia+1]};
                e.rdata = sg ? {{16{h[15]}}, h} : {16'h0, h};
            end else begin
                e.rdata = ref_word(base / 4);
            end
        end else begin
            e.nwr = 1;
            e.nrd = sz[1] ? 0 : 1;
            e.lat = sz[1] ? 2 : 3;
            for (int k = 0; k < 4; k++) bb[k] = rm[base+k];
            if (sz == 2'd0) begin
                bb[off] = wd[7:0];
            end else if (sz == 2'd1) begin
                bb[off] = wd[15:8];
                bb[off+1] = wd[7:0];
            end else begin
                bb[0] = wd[31:24];
                bb[1] = wd[23:16];
                bb[2] = wd[15:8];
                bb[3] = wd[7:0];
            end
            e.wword = {bb[0], bb[1], bb[2], bb[3]};
        end
        return e;
    endfunction

    task automatic ref_commit(input logic [9:0] a, input exp_t e);
        int base;
        base = int'(a) & ~3;
        if (e.nwr == 1) begin
            rm[base]   = e.wword[31:24];
            rm[base+1] = e.wword[23:16];
            rm[base+2] = e.wword[15:8];
            rm[base+3] = e.wword[7:0];
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge CLK);
        pl_en = 1'b1;
        pl_a = 8'(w);
        pl_d = d;
        @(posedge CLK);
        #1 pl_en = 1'b0;
        rm[4*w]   = d[31:24];
        rm[4*w+1] = d[23:16];
        rm[4*w+2] = d[15:8];
        rm[4*w+3] = d[7:0];
    endtask

    // Issue one request and record what the DUT did, cycle by cycle
    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [9:0] a, input logic [31:0] wd,
                        output obs_t o);
        o.lat = -1;
        o.rdata = '0;
        o.err = 1'b0;
        o.nrd = 0;
        o.nwr = 0;
        o.wdata = '0;
        o.waddr = '0;
        @(negedge CLK);
        o.rdy = req_ready;
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        @(posedge CLK);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                req_valid = 1'b0;
                req_we = 1'($urandom);
                req_size = 2'($urandom);
                req_signed = 1'($urandom);
                req_addr = 10'($urandom);
                req_wdata = $urandom;
            end
            #1;
            if (mem_rd) begin
                o.nrd++;
                o.waddr = mem_addr;
            end
            if (mem_wr) begin
                o.nwr++;
                o.wdata = mem_wdata;
                o.waddr = mem_addr;
            end
            if (resp_valid) begin
                o.lat = c;
                o.rdata = resp_rdata;
                o.err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", req_ready);
        end
        total++;
        if ({resp_valid, resp_err, mem_rd, mem_wr} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {resp_valid, resp_err, mem_rd, mem_wr});
        end
        total++;
        if ({resp_rdata, mem_wdata, mem_addr} !== 72'h0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h want=0",
                     resp_rdata, mem_wdata, mem_addr);
        end
        RST_N = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
        for (int w = 0; w < 16; w++) preload(w, $urandom);
    endtask

    task automatic test_loads();
        logic [1:0]  sz [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        logic        sg [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [9:0]  ad [7] = '{10'h15, 10'h15, 10'h17, 10'h16, 10'h14,
                                10'h14, 10'h14};
        logic [31:0] ex [7] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFFFBB,
                                32'hFFFFAABB, 32'h00008899, 32'h8899AABB,
                                32'h8899AABB};
        obs_t o;
        preload(5, 32'h8899AABB);
        for (int i = 0; i < 7; i++) begin
            xact(1'b0, sz[i], sg[i], ad[i], 32'h0, o);
            total++;
            if (o.rdata !== ex[i] || o.err !== 1'b0 || o.lat != 2) begin
                bad++;
                $display("FAIL load_%0d got=%h err=%b lat=%0d want=%h err=0 lat=2",
                         i, o.rdata, o.err, o.lat, ex[i]);
            end
        end
    endtask

    task automatic test_stores();
        obs_t o;
        exp_t e;
        preload(5, 32'h11223344);
        e = model(1'b1, 2'd1, 1'b0, 10'h16, 32'hDEADBEEF);
        xact(1'b1, 2'd1, 1'b0, 10'h16, 32'hDEADBEEF, o);
        ref_commit(10'h16, e);
        total++;
        if (o.wdata !== 32'h1122BEEF || o.waddr !== 8'd5 || o.lat != 3 ||
            o.nrd != 1 || o.nwr != 1) begin
            bad++;
            $display("FAIL sh got=%h a=%h lat=%0d rd=%0d wr=%0d want=1122BEEF a=05 lat=3 rd=1 wr=1",
                     o.wdata, o.waddr, o.lat, o.nrd, o.nwr);
        end
        xact(1'b0, 2'd2, 1'b0, 10'h14, 32'h0, o);
        total++;
        if (o.rdata !== 32'h1122BEEF || o.lat != 2) begin
            bad++;
            $display("FAIL lw_after_sh got=%h lat=%0d want=1122BEEF lat=2",
                     o.rdata, o.lat);
        end
        preload(8, 32'h0);
        e = model(1'b1, 2'd0, 1'b0, 10'h21, 32'h000000A5);
        xact(1'b1, 2'd0, 1'b0, 10'h21, 32'h000000A5, o);
        ref_commit(10'h21, e);
        total++;
        if (mem[8] !== 32'h00A50000 || o.lat != 3) begin
            bad++;
            $display("FAIL sb got=%h lat=%0d want=00A50000 lat=3", mem[8], o.lat);
        end
        e = model(1'b1, 2'd2, 1'b0, 10'h20, 32'hCAFEF00D);
        xact(1'b1, 2'd2, 1'b0, 10'h20, 32'hCAFEF00D, o);
        ref_commit(10'h20, e);
        total++;
        if (mem[8] !== 32'hCAFEF00D || o.nwr != 1 || o.nrd != 0 || o.lat != 2) begin
            bad++;
            $display("FAIL sw got=%h wr=%0d rd=%0d lat=%0d want=CAFEF00D wr=1 rd=0 lat=2",
                     mem[8], o.nwr, o.nrd, o.lat);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        logic [31:0] m4;
        logic [31:0] m5;
        m4 = mem[4];
        m5 = mem[5];
        xact(1'b0, 2'd2, 1'b1, 10'h16, 32'h0, o);
        total++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat != 1 ||
            o.nrd != 0 || o.nwr != 0) begin
            bad++;
            $display("FAIL mis_lw err=%b d=%h lat=%0d rd=%0d wr=%0d want err=1 d=0 lat=1 no strobes",
                     o.err, o.rdata, o.lat, o.nrd, o.nwr);
        end
        xact(1'b1, 2'd1, 1'b0, 10'h13, 32'h12345678, o);
        total++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat != 1 ||
            o.nrd != 0 || o.nwr != 0) begin
            bad++;
            $display("FAIL mis_sh err=%b d=%h lat=%0d rd=%0d wr=%0d want err=1 d=0 lat=1 no strobes",
                     o.err, o.rdata, o.lat, o.nrd, o.nwr);
        end
        total++;
        if (mem[4] !== m4 || mem[5] !== m5) begin
            bad++;
            $display("FAIL mis_mem got=%h %h want=%h %h", mem[4], mem[5], m4, m5);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  rdy;
        logic [6:0]  rv;
        logic [31:0] want;
        want = ref_word(5);
        @(negedge CLK);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'd2;
        req_signed = 1'b0;
        req_addr = 10'h14;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            rdy[i] = req_ready;
            rv[i] = resp_valid;
            if (resp_valid) begin
                total++;
                if (resp_rdata !== want) begin
                    bad++;
                    $display("FAIL b2b_data got=%h want=%h", resp_rdata, want);
                end
            end
            if (i == 5) req_valid = 1'b0;
        end
        total++;
        if (rdy !== 7'b1001001) begin
            bad++;
            $display("FAIL b2b_ready got=%b want=1001001", rdy);
        end
        total++;
        if (rv !== 7'b0100100) begin
            bad++;
            $display("FAIL b2b_resp got=%b want=0100100", rv);
        end
    endtask

    task automatic test_reset_mid_write();
        int nresp;
        preload(8, 32'h11223344);
        @(negedge CLK);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 10'h21;
        req_wdata = 32'h000000A5;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL rst_wr_gate got=%b want=0", mem_wr);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready_after got=%b want=1", req_ready);
        end
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) nresp++;
            @(negedge CLK);
            #1;
        end
        total++;
        if (nresp != 0) begin
            bad++;
            $display("FAIL rst_no_resp got=%0d want=0", nresp);
        end
        total++;
        if (mem[8] !== 32'h11223344) begin
            bad++;
            $display("FAIL rst_mem got=%h want=11223344", mem[8]);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [9:0]  a;
        logic [31:0] wd;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom);
            sz = 2'($urandom);
            sg = 1'($urandom);
            a = 10'($urandom_range(0, 63));
            wd = $urandom;
            e = model(we, sz, sg, a, wd);
            xact(we, sz, sg, a, wd, o);
            ref_commit(a, e);
            total++;
            if (o.rdy !== 1'b1 || o.lat != e.lat || o.err !== e.err ||
                o.rdata !== e.rdata || o.nrd != e.nrd || o.nwr != e.nwr) begin
                bad++;
                $display("FAIL rnd_%0d we=%b sz=%0d a=%h got d=%h e=%b lat=%0d rd=%0d wr=%0d want d=%h e=%b lat=%0d rd=%0d wr=%0d",
                         n, we, sz, a, o.rdata, o.err, o.lat, o.nrd, o.nwr,
                         e.rdata, e.err, e.lat, e.nrd, e.nwr);
            end
            if (e.nwr == 1) begin
                total++;
                if (o.wdata !== e.wword || o.waddr !== a[9:2]) begin
                    bad++;
                    $display("FAIL rnd_wr_%0d got=%h@%h want=%h@%h",
                             n, o.wdata, o.waddr, e.wword, a[9:2]);
                end
            end
        end
        for (int w = 0; w < 16; w++) begin
            total++;
            if (mem[w] !== ref_word(w)) begin
                bad++;
                $display("FAIL rnd_mem_%0d got=%h want=%h", w, mem[w], ref_word(w));
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory (8-bit word address, 32-bit data, combinational read, write on CLK rising edge).
- Turns byte/halfword/word loads and stores into word accesses.
- Performs big-endian lane selection and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores and flags misaligned accesses.
- Presents a valid/ready request and a single-cycle response pulse to the pipeline.

Parameters:
- BADDR_W, 10, byte-address width; word address = addr[BADDR_W-1:2].
- WADDR_W, 8, word-address width driven to memory; must equal BADDR_W-2.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  BADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access; valid with resp_valid.
- mem_addr  out  WADDR_W  word address to the data memory.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-low (RST_N).
- Reset (RST_N low at an edge):
  - State goes to IDLE; all request registers clear.
  - resp_valid, resp_err, mem_rd, mem_wr go to 0; resp_rdata and mem_wdata go to 0.
  - req_ready = (state==IDLE) & RST_N, so it is 0 while reset is low.
- Accept: req_valid & req_ready at an edge latches we, size, signed, addr and wdata. Inputs are ignored in any other cycle.
- Misalignment check at accept:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
- States: IDLE, RD, WR, DONE.
  - IDLE → DONE: accepted request is misaligned; resp_err=1 in DONE, no memory access.
  - IDLE → RD: aligned load, or aligned byte/half store.
  - IDLE → WR: aligned word store.
  - RD: mem_rd=1, mem_addr=latched addr[9:2]; mem_rdata captured into a word register at the edge. Next state is WR for a store, DONE for a load.
  - WR: mem_wr = RST_N, mem_addr=latched word address, mem_wdata=merged word. Next state is DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Every memory strobe is combinational from state and is 0 in IDLE and DONE. mem_addr holds its last value outside RD/WR. The unit never relies on the memory's write-through read path.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - byte/half store: 3 cycles.
  - misaligned: 1 cycle.
- Throughput: the next request is accepted in the IDLE cycle after DONE; no back-to-back accept.
- Lane mapping (big-endian):
  - byte: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - half: addr[1]=0 → [31:16], addr[1]=1 → [15:0].
- Load result:
  - Selected lane is right-justified into resp_rdata.
  - Sign-extended if req_signed, else zero-extended.
  - Word loads ignore req_signed.
  - Driven only while resp_valid, 0 otherwise.
- Store merge:
  - The captured word has only the addressed lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
  - Upper bits of req_wdata are ignored.
- Reset mid-operation:
  - RST_N low during WR suppresses mem_wr in that same cycle, so no write occurs.
  - State returns to IDLE; no resp_valid is produced for the aborted request.
- req_ready stays 0 from the accept edge until DONE has completed.

Test Plan:
- Preload word 5 = 0x8899AABB; LB signed @0x15 → resp_rdata 0xFFFFFF99 at accept+2. LBU @0x15 → 0x00000099. LB @0x17 → 0xFFFFFFBB.
- Word 5 = 0x8899AABB; LH signed @0x16 → 0xFFFFAABB. LHU @0x14 → 0x00008899. LW @0x14 → 0x8899AABB with resp_err=0.
- Word 5 = 0x11223344; SH wdata 0xDEADBEEF @0x16 → RD then WR with mem_wdata 0x1122BEEF; resp_valid at accept+3. Following LW @0x14 → 0x1122BEEF.
- SB 0x000000A5 @0x21 over 0x00000000 → word 8 = 0x00A50000. SW 0xCAFEF00D @0x20 → exactly one mem_wr cycle, no mem_rd, word 8 = 0xCAFEF00D.
- LW @0x16 and SH @0x13 → resp_err=1, resp_rdata=0 at accept+1; mem_rd and mem_wr never assert; memory unchanged.
- Hold req_valid high continuously → req_ready drops after accept and a second request is taken only after DONE. Assert RST_N=0 in the WR cycle of SB @0x21 → mem_wr=0 that cycle, word unchanged, no resp_valid, req_ready=1 in the first cycle after RST_N returns high.
